// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the I/D-cache to DataMem arbiter: FSM state
// encoding, grant bit positions and the line-width derivation.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_t;

  // Bit positions inside the {d,i} grant vector.
  localparam int GRANT_I_BIT = 0;
  localparam int GRANT_D_BIT = 1;

  localparam logic [1:0] GRANT_NONE   = 2'b00;
  localparam logic [1:0] GRANT_I_MASK = 2'(1 << GRANT_I_BIT);
  localparam logic [1:0] GRANT_D_MASK = 2'(1 << GRANT_D_BIT);

  // A line holds 2**lineword_addr_len 32-bit words.
  function automatic int line_width(input int lineword_addr_len);
    return 32 << lineword_addr_len;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_line_latch.sv
// Per-master holding register for the last line returned by DataMem.
module mem_bus_arbiter_line_latch #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             capture,
  input  logic [WIDTH-1:0] line_in,
  output logic [WIDTH-1:0] line_out
);

  // Capture on the owner's handshake, otherwise hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_out <= '0;
    end else if (capture) begin
      line_out <= line_in;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (I-cache read-only, D-cache read/write-back) in front
// of the single line-granular DataMem port. Whole-line transactions are
// serialized with at least one idle cycle between them.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise the D-cache always wins a simultaneous request.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | no owner, mem_* outputs all zero, arbitrating
//   ST_GRANT_I | I-cache owns DataMem, waiting for handshake
//   ST_GRANT_D | D-cache owns DataMem, waiting for handshake
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAG_LEN           = 3,
  parameter int INDEX_ADDR_LEN    = 5,
  parameter int LINEWORD_ADDR_LEN = 2,
  parameter int MEM_ADDR_LEN      = TAG_LEN + INDEX_ADDR_LEN,
  parameter int LINE_W            = line_width(LINEWORD_ADDR_LEN)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_rd_req,
  input  logic [MEM_ADDR_LEN-1:0] i_addr,
  output logic [LINE_W-1:0]       i_rd_line,
  output logic                    i_handshake,
  input  logic                    d_rd_req,
  input  logic                    d_wr_req,
  input  logic [MEM_ADDR_LEN-1:0] d_addr,
  input  logic [LINE_W-1:0]       d_wr_line,
  output logic [LINE_W-1:0]       d_rd_line,
  output logic                    d_handshake,
  output logic                    mem_rd_req,
  output logic                    mem_wr_req,
  output logic [MEM_ADDR_LEN-1:0] mem_addr,
  output logic [LINE_W-1:0]       mem_wr_line,
  input  logic [LINE_W-1:0]       mem_rd_line,
  input  logic                    mem_handshake,
  output logic [1:0]              grant
);

  arb_state_t        state;
  logic              i_pend;
  logic              d_pend;
  logic              pick_d;
  logic              i_hs;
  logic              d_hs;
  logic [LINE_W-1:0] i_latch;
  logic [LINE_W-1:0] d_latch;

  assign i_pend = i_rd_req;
  assign d_pend = d_rd_req | d_wr_req;

  // A handshake only counts while the owner is still requesting.
  assign i_hs = (state == ST_GRANT_I) & i_pend & mem_handshake;
  assign d_hs = (state == ST_GRANT_D) & d_pend & mem_handshake;

  assign i_handshake = i_hs;
  assign d_handshake = d_hs;

  // Fresh data passes straight through in the handshake cycle.
  assign i_rd_line = i_hs ? mem_rd_line : i_latch;
  assign d_rd_line = d_hs ? mem_rd_line : d_latch;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  // On a tie, D wins unless D was the most recent grant.
  assign pick_d = d_pend & (~i_pend | ~last_d);

  // Remember which master was granted last; reset means "I last".
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_d <= 1'b0;
    end else if ((state == ST_IDLE) && (i_pend || d_pend)) begin
      last_d <= pick_d;
    end
  end
`else
  assign pick_d = d_pend;
`endif

  // Arbitration FSM with registered grant vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      grant <= GRANT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_d) begin
            state <= ST_GRANT_D;
            grant <= GRANT_D_MASK;
          end else if (i_pend) begin
            state <= ST_GRANT_I;
            grant <= GRANT_I_MASK;
          end
        end
        ST_GRANT_I: begin
          if (!i_pend || mem_handshake) begin
            state <= ST_IDLE;
            grant <= GRANT_NONE;
          end
        end
        ST_GRANT_D: begin
          if (!d_pend || mem_handshake) begin
            state <= ST_IDLE;
            grant <= GRANT_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= GRANT_NONE;
        end
      endcase
    end
  end

  // Route the owner's request onto the DataMem port; idle drives zeros.
  always_comb begin
    mem_rd_req  = 1'b0;
    mem_wr_req  = 1'b0;
    mem_addr    = '0;
    mem_wr_line = '0;
    case (state)
      ST_GRANT_I: begin
        mem_rd_req = i_rd_req;
        mem_addr   = i_addr;
      end
      ST_GRANT_D: begin
        mem_rd_req  = d_rd_req;
        mem_wr_req  = d_wr_req;
        mem_addr    = d_addr;
        mem_wr_line = d_wr_line;
      end
      default: ;
    endcase
  end

  mem_bus_arbiter_line_latch #(.WIDTH(LINE_W)) u_i_latch (
    .clk      (clk),
    .rstn     (rstn),
    .capture  (i_hs),
    .line_in  (mem_rd_line),
    .line_out (i_latch)
  );

  mem_bus_arbiter_line_latch #(.WIDTH(LINE_W)) u_d_latch (
    .clk      (clk),
    .rstn     (rstn),
    .capture  (d_hs),
    .line_in  (mem_rd_line),
    .line_out (d_latch)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a transaction-level
// ownership model. Expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_mem_bus_arbiter;

  localparam int AW = 8;
  localparam int LW = 128;

  localparam logic [LW-1:0] LINE_A = 128'hA5A5_0001_A5A5_0002_A5A5_0003_A5A5_0004;
  localparam logic [LW-1:0] LINE_B = 128'hB00B_1111_B00B_2222_B00B_3333_B00B_4444;
  localparam logic [LW-1:0] LINE_C = 128'hC0DE_5555_C0DE_6666_C0DE_7777_C0DE_8888;
  localparam logic [LW-1:0] LINE_D = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0;

  logic          clk;
  logic          rstn;
  logic          i_rd_req;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rd_line;
  logic          i_handshake;
  logic          d_rd_req;
  logic          d_wr_req;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wr_line;
  logic [LW-1:0] d_rd_line;
  logic          d_handshake;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wr_line;
  logic [LW-1:0] mem_rd_line;
  logic          mem_handshake;
  logic [1:0]    grant;

  mem_bus_arbiter dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_rd_req      (i_rd_req),
    .i_addr        (i_addr),
    .i_rd_line     (i_rd_line),
    .i_handshake   (i_handshake),
    .d_rd_req      (d_rd_req),
    .d_wr_req      (d_wr_req),
    .d_addr        (d_addr),
    .d_wr_line     (d_wr_line),
    .d_rd_line     (d_rd_line),
    .d_handshake   (d_handshake),
    .mem_rd_req    (mem_rd_req),
    .mem_wr_req    (mem_wr_req),
    .mem_addr      (mem_addr),
    .mem_wr_line   (mem_wr_line),
    .mem_rd_line   (mem_rd_line),
    .mem_handshake (mem_handshake),
    .grant         (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns DataMem (0 none, 1 I-cache, 2 D-cache), who was granted
  // last, and the line each cache would see when not in a handshake cycle.
  int            m_owner;
  bit            m_last_d;
  logic [LW-1:0] m_iline;
  logic [LW-1:0] m_dline;
  bit            i_done;
  bit            d_done;

  task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_owner  = 0;
    m_last_d = 1'b0;
    m_iline  = '0;
    m_dline  = '0;
  endtask

  // Check every output mid-cycle, then advance the model to the next cycle.
  task automatic cycle_check();
    logic          ireq, dreq, ihs, dhs, win_d;
    logic [1:0]    e_grant;
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wline;
    int            n_owner;
    bit            n_last_d;
    logic [LW-1:0] n_iline, n_dline;
    @(negedge clk);
    ireq    = i_rd_req;
    dreq    = d_rd_req | d_wr_req;
    ihs     = (m_owner == 1) && ireq && mem_handshake;
    dhs     = (m_owner == 2) && dreq && mem_handshake;
    e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    e_rd    = (m_owner == 1) ? i_rd_req : (m_owner == 2) ? d_rd_req : 1'b0;
    e_wr    = (m_owner == 2) ? d_wr_req : 1'b0;
    e_addr  = (m_owner == 1) ? i_addr : (m_owner == 2) ? d_addr : '0;
    e_wline = (m_owner == 2) ? d_wr_line : '0;
    check_eq("grant",       LW'(grant),       LW'(e_grant));
    check_eq("mem_rd_req",  LW'(mem_rd_req),  LW'(e_rd));
    check_eq("mem_wr_req",  LW'(mem_wr_req),  LW'(e_wr));
    check_eq("mem_addr",    LW'(mem_addr),    LW'(e_addr));
    check_eq("mem_wr_line", mem_wr_line,      e_wline);
    check_eq("i_handshake", LW'(i_handshake), LW'(ihs));
    check_eq("d_handshake", LW'(d_handshake), LW'(dhs));
    check_eq("i_rd_line",   i_rd_line,        ihs ? mem_rd_line : m_iline);
    check_eq("d_rd_line",   d_rd_line,        dhs ? mem_rd_line : m_dline);
    n_owner  = m_owner;
    n_last_d = m_last_d;
    n_iline  = m_iline;
    n_dline  = m_dline;
    if (!rstn) begin
      n_owner  = 0;
      n_last_d = 1'b0;
      n_iline  = '0;
      n_dline  = '0;
    end else if (m_owner == 0) begin
      if (ireq || dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_d = dreq && (!ireq || !m_last_d);
`else
        win_d = dreq;
`endif
        n_owner  = win_d ? 2 : 1;
        n_last_d = win_d;
      end
    end else if (m_owner == 1) begin
      if (ihs) n_iline = mem_rd_line;
      if (ihs || !ireq) n_owner = 0;
    end else begin
      if (dhs) n_dline = mem_rd_line;
      if (dhs || !dreq) n_owner = 0;
    end
    i_done = ihs;
    d_done = dhs;
    @(posedge clk);
    #1;
    m_owner  = n_owner;
    m_last_d = n_last_d;
    m_iline  = n_iline;
    m_dline  = n_dline;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    cycle_check();
    rstn = 1'b1;
  endtask

  initial begin
    logic [1:0]    tie_exp;
    logic [LW-1:0] saved;
    int            prev_owner;
    int            lat;
    logic          owner_req;

    rstn          = 1'b0;
    i_rd_req      = 1'b0;
    i_addr        = '0;
    d_rd_req      = 1'b0;
    d_wr_req      = 1'b0;
    d_addr        = '0;
    d_wr_line     = '0;
    mem_rd_line   = '0;
    mem_handshake = 1'b0;
    i_done        = 1'b0;
    d_done        = 1'b0;
    model_reset();
    cycle_check();
    cycle_check();
    rstn = 1'b1;

    // I-cache read of line 0x25, handshake on the third granted cycle.
    i_rd_req = 1'b1;
    i_addr   = 8'h25;
    cycle_check();
    check_eq("t1_mem_rd_req", LW'(mem_rd_req), LW'(1'b1));
    check_eq("t1_mem_addr",   LW'(mem_addr),   LW'(8'h25));
    cycle_check();
    cycle_check();
    mem_handshake = 1'b1;
    mem_rd_line   = LINE_A;
    cycle_check();
    mem_handshake = 1'b0;
    i_rd_req      = 1'b0;
    mem_rd_line   = ~LINE_A;
    check_eq("t1_line_hold", i_rd_line,   LINE_A);
    check_eq("t1_idle",      LW'(grant),  LW'(2'b00));
    cycle_check();

    // D write-back to 0x13 followed by a refill as a second transaction.
    d_wr_req  = 1'b1;
    d_addr    = 8'h13;
    d_wr_line = LINE_B;
    cycle_check();
    check_eq("t2_mem_wr_req",  LW'(mem_wr_req), LW'(1'b1));
    check_eq("t2_mem_wr_line", mem_wr_line,     LINE_B);
    cycle_check();
    mem_handshake = 1'b1;
    cycle_check();
    mem_handshake = 1'b0;
    d_wr_req      = 1'b0;
    d_rd_req      = 1'b1;
    check_eq("t2_gap", LW'(mem_rd_req), LW'(1'b0));
    cycle_check();
    check_eq("t2_refill_req", LW'(mem_rd_req), LW'(1'b1));
    mem_handshake = 1'b1;
    mem_rd_line   = LINE_C;
    cycle_check();
    mem_handshake = 1'b0;
    d_rd_req      = 1'b0;
    check_eq("t2_d_line", d_rd_line, LINE_C);
    cycle_check();

    // Four simultaneous requests from a freshly reset arbiter.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      i_rd_req = 1'b1;
      d_rd_req = 1'b1;
      i_addr   = 8'h30 + 8'(k);
      d_addr   = 8'h60 + 8'(k);
      cycle_check();
`ifdef ARB_ROUND_ROBIN_EN
      tie_exp = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      tie_exp = 2'b10;
`endif
      check_eq("t3_tie_grant", LW'(grant), LW'(tie_exp));
      mem_handshake = 1'b1;
      mem_rd_line   = rand_line();
      cycle_check();
      mem_handshake = 1'b0;
      i_rd_req      = 1'b0;
      d_rd_req      = 1'b0;
      cycle_check();
    end

    // I request arrives while D owns the port.
    d_rd_req = 1'b1;
    d_addr   = 8'h40;
    i_addr   = 8'h77;
    cycle_check();
    i_rd_req = 1'b1;
    cycle_check();
    cycle_check();
    mem_handshake = 1'b1;
    mem_rd_line   = rand_line();
    cycle_check();
    mem_handshake = 1'b0;
    d_rd_req      = 1'b0;
    cycle_check();
    check_eq("t4_i_granted", LW'(grant), LW'(2'b01));
    mem_handshake = 1'b1;
    mem_rd_line   = rand_line();
    cycle_check();
    mem_handshake = 1'b0;
    i_rd_req      = 1'b0;
    cycle_check();

    // Asynchronous reset in the middle of a D write-back.
    d_wr_req  = 1'b1;
    d_addr    = 8'h5a;
    d_wr_line = LINE_D;
    cycle_check();
    cycle_check();
    #2;
    rstn = 1'b0;
    #1;
    check_eq("t5_async_wr_req", LW'(mem_wr_req), LW'(1'b0));
    check_eq("t5_async_grant",  LW'(grant),      LW'(2'b00));
    model_reset();
    cycle_check();
    rstn = 1'b1;
    cycle_check();
    check_eq("t5_regrant", LW'(grant), LW'(2'b10));
    mem_handshake = 1'b1;
    cycle_check();
    mem_handshake = 1'b0;
    d_wr_req      = 1'b0;
    cycle_check();

    // Owner abandons its request before any handshake.
    i_rd_req = 1'b1;
    i_addr   = 8'h11;
    saved    = m_iline;
    cycle_check();
    cycle_check();
    i_rd_req = 1'b0;
    cycle_check();
    check_eq("t6_back_idle",  LW'(grant), LW'(2'b00));
    check_eq("t6_line_kept",  i_rd_line,  saved);
    cycle_check();

    // Randomized traffic with a reactive DataMem of 0..3 cycles latency.
    prev_owner = 0;
    lat        = 0;
    for (int c = 0; c < 1500; c++) begin
      if (i_rd_req) begin
        if (i_done || ($urandom_range(0, 39) == 0)) i_rd_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        i_rd_req = 1'b1;
        i_addr   = 8'($urandom);
      end
      if (d_rd_req || d_wr_req) begin
        if (d_done) begin
          if (d_wr_req && ($urandom_range(0, 1) == 1)) begin
            d_wr_req = 1'b0;
            d_rd_req = 1'b1;
          end else begin
            d_wr_req = 1'b0;
            d_rd_req = 1'b0;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          d_wr_req = 1'b0;
          d_rd_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) d_wr_req = 1'b1;
        else d_rd_req = 1'b1;
        d_addr    = 8'($urandom);
        d_wr_line = rand_line();
      end
      mem_rd_line = rand_line();
      owner_req   = (m_owner == 1) ? i_rd_req :
                    (m_owner == 2) ? (d_rd_req | d_wr_req) : 1'b0;
      if ((m_owner != prev_owner) && (m_owner != 0)) lat = $urandom_range(0, 3);
      prev_owner = m_owner;
      if (m_owner == 0) begin
        mem_handshake = ($urandom_range(0, 7) == 0);
      end else if (owner_req && (lat == 0)) begin
        mem_handshake = 1'b1;
      end else begin
        mem_handshake = 1'b0;
        if (lat > 0) lat--;
      end
      cycle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
